// File: rtl/demux2_16_buf.sv
// Steers each input word into one of two independent 2-entry output FIFOs selected by in_sel.
// Latency: one cycle from input acceptance to the channel outputs when that FIFO was empty.
// Backpressure: in_ready drops when the selected FIFO is full; there is no pass-through on a full FIFO.
// Optional transfer counters cnt0/cnt1 are built when DEMUX2_16_BUF_CNT_EN is defined.

// Small generic synchronous FIFO; head data reads as zero while the FIFO is empty.
module demux2_16_buf_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic             full,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is refused even if the head pops this same cycle.
    assign full     = (count == FULL_CNT);
    assign head_vld = (count != '0);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;
    assign do_push  = push_vld & ~full;
    assign do_pop   = pop_rdy & head_vld;

    // Storage array; needs no reset because reads are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy update; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module demux2_16_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
`ifdef DEMUX2_16_BUF_CNT_EN
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1,
`endif
    input  logic             out1_ready
);
    logic full0;
    logic full1;
    logic push0;
    logic push1;

    // Ready depends only on the selected channel's fullness, never on in_valid.
    assign in_ready = in_sel ? ~full1 : ~full0;
    assign push0    = in_valid & in_ready & ~in_sel;
    assign push1    = in_valid & in_ready &  in_sel;

    demux2_16_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push0),
        .push_dat (in_data),
        .pop_rdy  (out0_ready),
        .full     (full0),
        .head_vld (out0_valid),
        .head_dat (out0_data)
    );

    demux2_16_buf_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push1),
        .push_dat (in_data),
        .pop_rdy  (out1_ready),
        .full     (full1),
        .head_vld (out1_valid),
        .head_dat (out1_data)
    );

`ifdef DEMUX2_16_BUF_CNT_EN
    // Per-channel output transfer counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) begin
                cnt0 <= cnt0 + 16'd1;
            end
            if (out1_valid && out1_ready) begin
                cnt1 <= cnt1 + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_demux2_16_buf.sv
// Directed-vector bench for demux2_16_buf with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// Counter checks are compiled only when DEMUX2_16_BUF_CNT_EN is defined.
module tb_demux2_16_buf;
    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out0_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
`ifdef DEMUX2_16_BUF_CNT_EN
    logic [15:0] cnt0;
    logic [15:0] cnt1;
`endif

    int vec_cnt  = 0;
    int miscmp   = 0;

    demux2_16_buf #(.WIDTH(16), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
`ifdef DEMUX2_16_BUF_CNT_EN
        .cnt0       (cnt0),
        .cnt1       (cnt1),
`endif
        .out1_ready (out1_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock: inputs are updated 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic push(input logic sel, input logic [15:0] d);
        in_sel   = sel;
        in_data  = d;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;

        // Reset state
        step();
        settle();
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(out1_valid), 32'd0);
        chk("rst_out0_data",  32'(out0_data),  32'd0);
        chk("rst_out1_data",  32'(out1_data),  32'd0);
        step();
        rst_n = 1'b1;
        in_sel = 1'b0; settle();
        chk("rst_rdy_sel0", 32'(in_ready), 32'd1);
        in_sel = 1'b1; settle();
        chk("rst_rdy_sel1", 32'(in_ready), 32'd1);
        step();

        // Single word to channel 0
        in_sel = 1'b0; in_data = 16'hA5A5; in_valid = 1'b1; settle();
        chk("single_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0; in_data = 16'hFFFF; settle();
        chk("single_out0_valid", 32'(out0_valid), 32'd1);
        chk("single_out0_data",  32'(out0_data),  32'hA5A5);
        chk("single_out1_valid", 32'(out1_valid), 32'd0);
        step(); settle();
        chk("single_hold_data", 32'(out0_data), 32'hA5A5);
        out0_ready = 1'b1;
        step();
        out0_ready = 1'b0; settle();
        chk("single_drained_valid", 32'(out0_valid), 32'd0);
        chk("single_drained_data",  32'(out0_data),  32'd0);

        // Fill channel 1 under backpressure
        push(1'b1, 16'h0001);
        push(1'b1, 16'h0002);
        in_sel = 1'b1; settle();
        chk("full_rdy_sel1", 32'(in_ready), 32'd0);
        in_sel = 1'b0; settle();
        chk("full_rdy_sel0", 32'(in_ready), 32'd1);
        step(); settle();
        chk("full_hold_data", 32'(out1_data), 32'h0001);
        // No pass-through on a full FIFO even with out1_ready high
        in_sel = 1'b1; in_data = 16'h0003; in_valid = 1'b1; out1_ready = 1'b1; settle();
        chk("full_nopass_rdy", 32'(in_ready),  32'd0);
        chk("full_pop1_data",  32'(out1_data), 32'h0001);
        step();
        in_valid = 1'b0; settle();
        chk("full_pop2_data",  32'(out1_data), 32'h0002);
        chk("full_pop2_valid", 32'(out1_valid), 32'd1);
        step();
        out1_ready = 1'b0; settle();
        chk("full_empty_valid", 32'(out1_valid), 32'd0);

        // Simultaneous push and pop at occupancy 1
        push(1'b0, 16'h1111);
        in_sel = 1'b0; in_data = 16'h2222; in_valid = 1'b1; out0_ready = 1'b1; settle();
        chk("pp_head_before", 32'(out0_data), 32'h1111);
        step();
        in_valid = 1'b0; out0_ready = 1'b0; settle();
        chk("pp_head_after",  32'(out0_data),  32'h2222);
        chk("pp_valid_after", 32'(out0_valid), 32'd1);
        chk("pp_occ1_ready",  32'(in_ready),   32'd1);
        push(1'b0, 16'h3333);
        in_sel = 1'b0; settle();
        chk("pp_occ2_ready", 32'(in_ready), 32'd0);
        out0_ready = 1'b1;
        step(); settle();
        chk("pp_drain_3333", 32'(out0_data), 32'h3333);
        step();
        out0_ready = 1'b0; settle();
        chk("pp_drain_empty", 32'(out0_valid), 32'd0);

        // Pop on an empty channel and idle input change nothing
        out1_ready = 1'b1; in_sel = 1'b1; in_data = 16'hFFFF; in_valid = 1'b0;
        step(); step();
        out1_ready = 1'b0; settle();
        chk("idle_out1_valid", 32'(out1_valid), 32'd0);
        chk("idle_out1_data",  32'(out1_data),  32'd0);

        // Alternating channels with both readies high
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_sel = i[0]; in_data = 16'h0010 + 16'(i); in_valid = 1'b1;
            step();
            in_valid = 1'b0; settle();
            if (i[0]) begin
                chk("alt_ch1_data",  32'(out1_data),  32'h0010 + 32'(i));
                chk("alt_ch1_valid", 32'(out1_valid), 32'd1);
                chk("alt_ch0_idle",  32'(out0_valid), 32'd0);
            end else begin
                chk("alt_ch0_data",  32'(out0_data),  32'h0010 + 32'(i));
                chk("alt_ch0_valid", 32'(out0_valid), 32'd1);
                chk("alt_ch1_idle",  32'(out1_valid), 32'd0);
            end
        end
        step();
        out0_ready = 1'b0; out1_ready = 1'b0;

        // Asynchronous reset with both FIFOs full
        push(1'b0, 16'hAAAA);
        push(1'b0, 16'hBBBB);
        push(1'b1, 16'hCCCC);
        push(1'b1, 16'hDDDD);
        in_sel = 1'b0; settle();
        chk("mid_full_rdy0", 32'(in_ready), 32'd0);
        in_sel = 1'b1; settle();
        chk("mid_full_rdy1", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out0_valid", 32'(out0_valid), 32'd0);
        chk("arst_out1_valid", 32'(out1_valid), 32'd0);
        chk("arst_out0_data",  32'(out0_data),  32'd0);
        chk("arst_out1_data",  32'(out1_data),  32'd0);
        // An edge with reset low must not accept a word
        in_sel = 1'b1; in_data = 16'h7777; in_valid = 1'b1;
        step();
        in_valid = 1'b0; settle();
        chk("arst_no_push", 32'(out1_valid), 32'd0);
        rst_n = 1'b1;
        in_sel = 1'b0; settle();
        chk("rel_rdy_sel0", 32'(in_ready), 32'd1);
        in_sel = 1'b1; settle();
        chk("rel_rdy_sel1", 32'(in_ready), 32'd1);
        push(1'b1, 16'h0055);
        settle();
        chk("rel_push_data",  32'(out1_data),  32'h0055);
        chk("rel_push_valid", 32'(out1_valid), 32'd1);

`ifdef DEMUX2_16_BUF_CNT_EN
        // Counter wrap: 65537 transfers on channel 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; settle();
        chk("cnt0_reset", 32'(cnt0), 32'd0);
        chk("cnt1_reset", 32'(cnt1), 32'd0);
        in_sel = 1'b0; in_data = 16'h1234; in_valid = 1'b1; out0_ready = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            step();
        end
        in_valid = 1'b0;
        step();
        out0_ready = 1'b0; settle();
        chk("cnt0_wrap", 32'(cnt0), 32'h0001);
        chk("cnt1_idle", 32'(cnt1), 32'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end
endmodule
